// File: rtl/score_tracker.sv
// Score tracker: counts pipes whose trailing edge passes the bird column on game
// ticks, keeps a session high score and flags a new record for the display.
module score_tracker #(
  parameter logic [9:0]  BIRD_X    = 10'd200,
  parameter logic [9:0]  PIPE_W    = 10'd60,
  parameter logic [10:0] MAX_SCORE = 11'd999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        gamestate,
  input  logic        pause,
  input  logic [9:0]  pipe_x,
  output logic [10:0] score,
  output logic [10:0] high_score,
  output logic        point,
  output logic        new_record,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] score_q, score_d;
  logic [10:0] high_q, high_d;
  logic        point_q, point_d;
  logic        rec_q, rec_d;
  logic        prev_valid_q, prev_valid_d;
  logic [10:0] prev_edge_q, prev_edge_d;
  logic        gs_q;

  logic [10:0] edge_w;
  logic [10:0] bx_w;
  logic        rise_w;
  logic        fall_w;
  logic        crossing_w;

  assign edge_w     = {1'b0, pipe_x} + {1'b0, PIPE_W};
  assign bx_w       = {1'b0, BIRD_X};
  assign rise_w     = gamestate & ~gs_q;
  assign fall_w     = ~gamestate & gs_q;
  // A respawned pipe has a larger edge than before, so it never satisfies this.
  assign crossing_w = prev_valid_q && (prev_edge_q >= bx_w) && (edge_w < bx_w);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      score_q      <= '0;
      high_q       <= '0;
      point_q      <= 1'b0;
      rec_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_edge_q  <= '0;
      gs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      point_q      <= point_d;
      rec_q        <= rec_d;
      prev_valid_q <= prev_valid_d;
      prev_edge_q  <= prev_edge_d;
      gs_q         <= gamestate;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    point_d      = 1'b0;
    rec_d        = rec_q;
    prev_valid_d = prev_valid_q;
    prev_edge_d  = prev_edge_q;

    if (fall_w) begin
      state_d = OVER;
    end else if ((state_q == IDLE || state_q == OVER) && rise_w) begin
      state_d      = RUN;
      score_d      = '0;
      rec_d        = 1'b0;
      prev_valid_d = 1'b0;
    end else if (state_q == RUN && pause) begin
      state_d = PAUSED;
    end else if (state_q == PAUSED && !pause) begin
      state_d = RUN;
    end else if (state_q == RUN && tick) begin
      prev_edge_d  = edge_w;
      prev_valid_d = 1'b1;
      if (crossing_w && score_q < MAX_SCORE) begin
        score_d = score_q + 11'd1;
        point_d = 1'b1;
      end
    end

    // Track the record against the score being written this edge.
    if (score_d > high_q) begin
      high_d = score_d;
      rec_d  = 1'b1;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign point      = point_q;
  assign new_record = rec_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed scenarios plus random play, all checked
// against a cycle-level game model built from the scoring rules.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        tick = 1'b0;
  logic        gamestate = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  pipe_x = 10'd0;
  logic [10:0] score;
  logic [10:0] high_score;
  logic        point;
  logic        new_record;
  logic [1:0]  state;

  score_tracker dut (
    .clk        (clk),
    .clr        (clr),
    .tick       (tick),
    .gamestate  (gamestate),
    .pause      (pause),
    .pipe_x     (pipe_x),
    .score      (score),
    .high_score (high_score),
    .point      (point),
    .new_record (new_record),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the game: 0 IDLE, 1 RUN, 2 PAUSED, 3 OVER.
  int m_state, m_score, m_high, m_point, m_rec, m_pv, m_pe, m_gs;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_point = 0;
    m_rec = 0; m_pv = 0; m_pe = 0; m_gs = 0;
  endtask

  task automatic model_clock(input int t, input int g, input int p, input int x);
    int e;
    m_point = 0;
    e = x + 60;
    if (m_gs == 1 && g == 0) begin
      m_state = 3;
    end else if ((m_state == 0 || m_state == 3) && g == 1 && m_gs == 0) begin
      m_state = 1; m_score = 0; m_rec = 0; m_pv = 0;
    end else if (m_state == 1 && p == 1) begin
      m_state = 2;
    end else if (m_state == 2 && p == 0) begin
      m_state = 1;
    end else if (m_state == 1 && t == 1) begin
      if (m_pv == 1 && m_pe >= 200 && e < 200 && m_score < 999) begin
        m_score++;
        m_point = 1;
      end
      m_pv = 1;
      m_pe = e;
    end
    if (m_score > m_high) begin
      m_high = m_score;
      m_rec  = 1;
    end
    m_gs = g;
  endtask

  task automatic check_all();
    check("score", int'(score), m_score);
    check("high_score", int'(high_score), m_high);
    check("point", int'(point), m_point);
    check("new_record", int'(new_record), m_rec);
    check("state", int'(state), m_state);
  endtask

  task automatic step(input logic t, input logic g, input logic p, input logic [9:0] x);
    @(negedge clk);
    tick = t; gamestate = g; pause = p; pipe_x = x;
    @(posedge clk);
    model_clock(int'(t), int'(g), int'(p), int'(x));
    #1;
    check_all();
  endtask

  task automatic idle(input logic g, input logic p);
    step(1'b0, g, p, pipe_x);
  endtask

  initial begin
    logic [9:0] px;
    logic       g, p;
    model_reset();
    #23;
    check_all();
    @(negedge clk);
    clr = 1'b0;
    $display("phase reset: score=%0d state=%0d", score, state);

    // Basic crossing sequence.
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd300);
    step(1, 1, 0, 10'd200);
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd139);
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd130);
    check("basic_score", int'(score), 1);
    $display("phase basic: score=%0d high=%0d rec=%0d", score, high_score, new_record);

    // First tick after a new game only primes the previous edge.
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd100);
    step(1, 1, 0, 10'd90);
    check("prime_score", int'(score), 0);
    $display("phase prime: score=%0d high=%0d rec=%0d", score, high_score, new_record);

    // Pause freezes scoring but keeps the previous edge.
    step(1, 1, 0, 10'd150);
    idle(1'b1, 1'b1);
    step(1, 1, 1, 10'd150);
    step(1, 1, 1, 10'd130);
    check("paused_state", int'(state), 2);
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd120);
    $display("phase pause: score=%0d state=%0d", score, state);

    // Respawn is not a crossing.
    step(1, 1, 0, 10'd5);
    step(1, 1, 0, 10'd640);
    $display("phase respawn: score=%0d point=%0d", score, point);

    // Crossing on the same edge that the bird dies.
    step(1, 1, 0, 10'd150);
    step(1, 0, 0, 10'd130);
    check("death_state", int'(state), 3);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    $display("phase death: score=%0d high=%0d rec=%0d", score, high_score, new_record);

    // Saturation at the maximum score.
    for (int i = 0; i < 1010; i++) begin
      step(1, 1, 0, 10'd150);
      step(1, 1, 0, 10'd130);
    end
    check("sat_score", int'(score), 999);
    check("sat_high", int'(high_score), 999);
    $display("phase saturate: score=%0d high=%0d", score, high_score);

    // Random play.
    px = 10'd600; g = 1'b1; p = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) g = ~g;
      if ($urandom_range(0, 39) == 0) p = ~p;
      if ($urandom_range(0, 2) == 0) begin
        if (px < 10'd20) px = 10'($urandom_range(500, 700));
        else px = px - 10'($urandom_range(1, 15));
        step(1'b1, g, p, px);
      end else begin
        step(1'b0, g, p, 10'($urandom_range(0, 1023)));
      end
    end
    $display("phase random: score=%0d high=%0d state=%0d", score, high_score, state);

    // Asynchronous clear mid-game.
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    step(1, 1, 0, 10'd300);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 10'd150);
      step(1, 1, 0, 10'd130);
    end
    check("pre_clr_score", int'(score), 5);
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    clr = 1'b0;
    gamestate = 1'b0;
    idle(1'b0, 1'b0);
    $display("phase clear: score=%0d state=%0d", score, state);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Game-logic stage that produces the 11-bit score consumed by the 7-segment display controller. It replaces the constant-zero score currently tied in the top level.
- Watches the pipe x-position and the game state from the VGA/game controller. On each game tick it detects the pipe's trailing edge passing the bird column and counts points.
- Keeps a session high score and flags a new record for the display.

Parameters:
- BIRD_X, 10'd200, fixed horizontal pixel column of the bird.
- PIPE_W, 10'd60, pipe width in pixels; trailing edge = pipe_x + PIPE_W.
- MAX_SCORE, 11'd999, saturation value for score and high_score.

Ports:
- clk  input  1  master clock, 100 MHz.
- clr  input  1  asynchronous, active-high reset.
- tick  input  1  game-step enable, one clk wide, once per game frame, synchronous to clk.
- gamestate  input  1  1 = bird alive/playing, 0 = dead/game over.
- pause  input  1  level; 1 freezes scoring.
- pipe_x  input  10  current pipe left-edge x, valid when tick=1.
- score  output  11  current game score, binary.
- high_score  output  11  best score since reset.
- point  output  1  one-clk pulse per scored point.
- new_record  output  1  score exceeded high_score during the current/last game.
- state  output  2  FSM state for debug: 0 IDLE, 1 RUN, 2 PAUSED, 3 OVER.

Behaviour:
- Reset (clr=1, async):
  - score=0, high_score=0, point=0, new_record=0, state=IDLE.
  - prev_valid=0, prev_edge=0, gs_d=0.
  - Reset mid-game discards everything.
- gs_d is gamestate registered every clk. rise = gamestate & ~gs_d; fall = ~gamestate & gs_d.
- FSM transitions, priority in the listed order:
  - Any state, fall → OVER. This beats all other events on the same edge; no point is awarded that edge.
  - IDLE or OVER, rise → RUN. On this transition: score=0, new_record=0, prev_valid=0.
  - RUN, pause=1 → PAUSED.
  - PAUSED, pause=0 → RUN. prev_valid is kept.
- Edge arithmetic:
  - edge = {1'b0,pipe_x} + {1'b0,PIPE_W}, 11 bits, no overflow.
  - bx = {1'b0,BIRD_X}.
- In RUN with tick=1, on that clk edge:
  - If prev_valid=0: prev_edge=edge, prev_valid=1, no scoring.
  - Otherwise, a crossing occurs when prev_edge >= bx and edge < bx.
  - prev_edge=edge is always updated.
- On a crossing:
  - If score < MAX_SCORE: score=score+1 and point=1 for exactly the next cycle.
  - If score == MAX_SCORE: score holds and point stays 0.
- Wrap-around: a pipe respawning at the right (edge > prev_edge) is not a crossing. Multiple pipes are the upstream block's problem; one pipe_x only.
- tick while in IDLE, PAUSED or OVER: ignored; prev_edge is not updated.
- high_score update:
  - Every clk in which score_next > high_score: high_score=score_next and new_record=1. The update happens on the same edge as the increment.
  - new_record stays high through OVER until the next rise.
- point is 0 in every cycle without a crossing. At most one increment per tick.
- Latency: from the tick edge to the score/point update is 1 clk. score is stable between ticks.
- score and high_score never exceed MAX_SCORE.

Test Plan:
- Reset, then gamestate=1, ticks with pipe_x = 300, 200, 139, 130 (edges 360, 260, 199, 190) → score 0→1 on the pipe_x=139 tick only. point high 1 cycle; high_score=1; new_record=1.
- First tick after rise with pipe_x=100 (edge 160 < 200) → no point, since prev_valid=0. Next tick pipe_x=90 → still 0.
- In RUN, pause=1, ticks with pipe_x 150→130 crossing → score unchanged, state=2. pause=0, then a tick with pipe_x=120 → prev from before pause (edge 210) vs 180 → score+1.
- Respawn: prev pipe_x=5 (edge 65), next pipe_x=640 (edge 700) → no point. Repeated crossings with score preloaded to 999 → score stays 999, point stays 0.
- Crossing tick in the same cycle gamestate falls → state=OVER, score unchanged. rise → score=0, high_score retained, new_record=0 until score passes high_score.
- clr pulsed mid-RUN with score=5 → all outputs 0 immediately, without waiting for a clk edge; state=IDLE.
